// File: rtl/code_lock_ctrl_if.sv
// rtl/code_lock_ctrl_if.sv - keypad-side and actuator-side signal bundle for the code lock
interface code_lock_ctrl_if #(
    parameter int DIGIT_W = 4,
    parameter int ATT_W   = 2
);
    logic               digit_valid;
    logic [DIGIT_W-1:0] digit;
    logic               enter;
    logic               clear;
    logic               change_req;
    logic               unlocked;
    logic               buzzer;
    logic               locked_out;
    logic [ATT_W-1:0]   attempts;
    logic [2:0]         state_o;

    // keypad decoder / actuator side
    modport master (
        output digit_valid, digit, enter, clear, change_req,
        input  unlocked, buzzer, locked_out, attempts, state_o
    );

    // lock controller side
    modport slave (
        input  digit_valid, digit, enter, clear, change_req,
        output unlocked, buzzer, locked_out, attempts, state_o
    );
endinterface

// File: rtl/code_lock_ctrl.sv
// rtl/code_lock_ctrl.sv - multi-digit keypad lock with timed unlock and wrong-try lockout
module code_lock_ctrl #(
    parameter int                               DIGIT_W        = 4,
    parameter int                               NUM_DIGITS     = 4,
    parameter int                               MAX_TRIES      = 3,
    parameter int                               UNLOCK_CYCLES  = 500,
    parameter int                               LOCKOUT_CYCLES = 1000,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0]    DEFAULT_CODE   = 16'h1234
) (
    input  logic             clk,
    input  logic             reset,
    code_lock_ctrl_if.slave  bus
);
    localparam int CODE_W  = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W   = $clog2(NUM_DIGITS + 1);
    localparam int ATT_W   = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENTRY    = 3'd1,
        CHECK    = 3'd2,
        OPEN     = 3'd3,
        SET_CODE = 3'd4,
        LOCKOUT  = 3'd5
    } state_t;

    state_t             state_q;
    logic [CODE_W-1:0]  code_q;
    logic [CODE_W-1:0]  buf_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ATT_W-1:0]   attempts_q;
    logic [TMR_W-1:0]   timer_q;
    logic               unlocked_q;
    logic               buzzer_q;
    logic               locked_out_q;

    logic [CODE_W-1:0]  buf_shift_d;
    logic [ATT_W-1:0]   att_inc_d;
    logic               digits_full_d;
    logic               match_d;

    // Helper terms shared by the entry, check and set-code states
    always_comb begin
        buf_shift_d   = CODE_W'({buf_q, bus.digit});
        att_inc_d     = attempts_q + ATT_W'(1);
        digits_full_d = (cnt_q == CNT_W'(NUM_DIGITS));
        match_d       = digits_full_d && (buf_q == code_q);
    end

    // Lock state machine; outputs are updated alongside the state so they stay registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            code_q       <= DEFAULT_CODE;
            buf_q        <= '0;
            cnt_q        <= '0;
            attempts_q   <= '0;
            timer_q      <= '0;
            unlocked_q   <= 1'b0;
            buzzer_q     <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // enter with nothing typed and clear with nothing typed both do nothing,
                    // but they still swallow a same-cycle digit
                    if (!bus.enter && !bus.clear && bus.digit_valid) begin
                        buf_q   <= CODE_W'(bus.digit);
                        cnt_q   <= CNT_W'(1);
                        state_q <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (bus.enter) begin
                        state_q <= CHECK;
                    end else if (bus.clear) begin
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (bus.digit_valid && !digits_full_d) begin
                        buf_q <= buf_shift_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                CHECK: begin
                    buf_q <= '0;
                    cnt_q <= '0;
                    if (match_d) begin
                        attempts_q <= '0;
                        timer_q    <= TMR_W'(UNLOCK_CYCLES - 1);
                        unlocked_q <= 1'b1;
                        state_q    <= OPEN;
                    end else begin
                        attempts_q <= att_inc_d;
                        if (att_inc_d == ATT_W'(MAX_TRIES)) begin
                            timer_q      <= TMR_W'(LOCKOUT_CYCLES - 1);
                            buzzer_q     <= 1'b1;
                            locked_out_q <= 1'b1;
                            state_q      <= LOCKOUT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                OPEN: begin
                    // a code change request wins over the final timer cycle
                    if (bus.change_req) begin
                        state_q <= SET_CODE;
                    end else if (timer_q == '0) begin
                        unlocked_q <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                SET_CODE: begin
                    if (bus.enter) begin
                        if (digits_full_d) begin
                            code_q <= buf_q;
                        end
                        buf_q      <= '0;
                        cnt_q      <= '0;
                        unlocked_q <= 1'b0;
                        state_q    <= IDLE;
                    end else if (bus.clear) begin
                        buf_q      <= '0;
                        cnt_q      <= '0;
                        unlocked_q <= 1'b0;
                        state_q    <= IDLE;
                    end else if (bus.digit_valid && !digits_full_d) begin
                        buf_q <= buf_shift_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LOCKOUT: begin
                    if (timer_q == '0) begin
                        attempts_q   <= '0;
                        buzzer_q     <= 1'b0;
                        locked_out_q <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.unlocked   = unlocked_q;
    assign bus.buzzer     = buzzer_q;
    assign bus.locked_out = locked_out_q;
    assign bus.attempts   = attempts_q;
    assign bus.state_o    = state_q;
endmodule

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
- Parametrised multi-digit keypad lock controller.
- Collects NUM_DIGITS serial digit entries, compares the full code against a stored code, and drives a timed unlock pulse.
- Counts wrong attempts; after MAX_TRIES failures it enforces a timed lockout with the buzzer on.
- Supports code change only while unlocked. Sits between the keypad decoder and the door actuator/buzzer driver.

Parameters:
- DIGIT_W, 4, bits per digit.
- NUM_DIGITS, 4, digits per code.
- MAX_TRIES, 3, consecutive wrong submissions that trigger lockout (>=1).
- UNLOCK_CYCLES, 500, clk cycles `unlocked` stays high (>=1).
- LOCKOUT_CYCLES, 1000, clk cycles of lockout (>=1).
- DEFAULT_CODE, 16'h1234, code loaded at reset; width DIGIT_W*NUM_DIGITS; first-entered digit is the MSB digit.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  reset, asynchronous, active-low.
- digit_valid  in  1  one-cycle strobe; `digit` is valid this cycle.
- digit  in  DIGIT_W  keypad digit value.
- enter  in  1  one-cycle submit strobe.
- clear  in  1  one-cycle strobe; discards the partial entry.
- change_req  in  1  one-cycle strobe; request code change (honoured only in OPEN).
- unlocked  out  1  high during OPEN and SET_CODE.
- buzzer  out  1  high during LOCKOUT.
- locked_out  out  1  high during LOCKOUT.
- attempts  out  clog2(MAX_TRIES+1)  current consecutive wrong-try count.
- state_o  out  3  state encoding for debug: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, SET_CODE=4, LOCKOUT=5.

Behaviour:
- Reset (async, reset=0) forces:
  - state=IDLE, stored code=DEFAULT_CODE;
  - entry buffer=0, digit count=0, attempts=0;
  - timer=0;
  - unlocked, buzzer, locked_out all 0.
- Entry buffer:
  - Each accepted digit shifts in as `buf <= {buf[lower], digit}`.
  - Digit count saturates at NUM_DIGITS; digits after that are ignored and do not set any flag.
- IDLE:
  - digit_valid: load the digit, count=1, go to ENTRY.
  - enter with no digits: ignored.
- ENTRY:
  - digit_valid: shift per the entry-buffer rule.
  - clear: count=0, buf=0, go to IDLE; attempts are unchanged.
  - enter: go to CHECK.
- Priority when strobes coincide in a cycle: enter > clear > digit_valid. The lower-priority strobes in that cycle are dropped.
- CHECK (exactly 1 cycle):
  - Match means count==NUM_DIGITS and buf==stored code.
  - Match: attempts=0, timer=UNLOCK_CYCLES-1, go to OPEN.
  - Mismatch, including a short entry: attempts+1.
    - If the new attempts value equals MAX_TRIES: timer=LOCKOUT_CYCLES-1, go to LOCKOUT.
    - Otherwise: go to IDLE.
  - buf and count are cleared on CHECK exit.
- Latency: from the `enter` cycle to `unlocked` or `locked_out` asserted is 2 clk edges.
- OPEN:
  - Timer decrements each cycle; go to IDLE the cycle after timer==0. `unlocked` is high exactly UNLOCK_CYCLES cycles.
  - change_req: go to SET_CODE; timer is frozen.
  - Input strobes other than change_req are ignored.
- SET_CODE:
  - digit_valid and clear follow the ENTRY rules.
  - enter with count==NUM_DIGITS: stored code=buf, go to IDLE.
  - enter with count<NUM_DIGITS: abort, keep the old code, go to IDLE.
  - There is no timeout in SET_CODE.
- LOCKOUT:
  - All keypad inputs are ignored. buzzer=locked_out=1 for exactly LOCKOUT_CYCLES cycles.
  - On exit: attempts=0, go to IDLE.
- All outputs are registered (decoded from the state register), with no combinational path from inputs.
- Reset mid-operation (any state) takes effect immediately and restores DEFAULT_CODE. A code that was changed is lost on reset.
- `attempts` never exceeds MAX_TRIES.

Test Plan:
- Reset, then keys 1,2,3,4 + enter -> CHECK, next cycle unlocked=1 for 500 cycles, attempts=0, then IDLE.
- Keys 1,2,3,5 + enter twice -> attempts=1 then 2. A third wrong entry -> locked_out=buzzer=1 for 1000 cycles, keys ignored during that time. After exit attempts=0 and 1,2,3,4 unlocks.
- Keys 1,2,3 + enter (short entry) -> counted as wrong, attempts=1. Keys 1,2,3,4,9 + enter -> 9 ignored, unlocks.
- While unlocked, change_req, keys 9,8,7,6 + enter -> IDLE. 1,2,3,4 now fails. 9,8,7,6 unlocks. Repeat with only 9,8 + enter -> code unchanged.
- Same-cycle digit_valid+enter after 1,2,3 -> digit dropped, short entry counted wrong. Key 1 then clear -> IDLE, attempts unchanged.
- Assert reset=0 mid-LOCKOUT and again after a code change -> all outputs 0 immediately. 1,2,3,4 unlocks again.
